operand_addr_seq: RTL and testbench

//  PDP-11 operand addressing sequencer: turns one 6-bit operand specifier into an

---
 rtl/operand_addr_seq.sv | 187 ++++++++++++++++++
 tb/tb_operand_addr_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_addr_seq.sv
// operand_addr_seq: PDP-11 operand addressing sequencer.
// Turns a 6-bit operand specifier {mode, reg} into an effective address.
// The sequencer drives the register file port and a req/ack memory read port.
// It handles autoincrement and autodecrement write-back.
// It fetches index words through PC and performs deferred memory reads.
// Optional feature macro: ODD_ADDR_TRAP_EN.
//   When defined, odd memory addresses and odd final word EAs abort with err.
//   When undefined, err is tied low and odd addresses go to memory unchanged.
module operand_addr_seq #(
    parameter logic [2:0] PC_REG = 3'd7,
    parameter logic [2:0] SP_REG = 3'd6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  spec,
    input  logic        byte_op,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic        is_reg,
    output logic [2:0]  rf_sel,
    input  logic [15:0] rf_rdata,
    output logic        rf_we,
    output logic [15:0] rf_wdata,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REG   = 3'd1;
    localparam logic [2:0] S_PCRD  = 3'd2;
    localparam logic [2:0] S_PCINC = 3'd3;
    localparam logic [2:0] S_MEM   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

`ifdef ODD_ADDR_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [2:0]  state_reg, state_next;
    logic [5:0]  spec_reg;
    logic        byte_reg;
    logic [15:0] tmp_reg, tmp_next;
    logic [15:0] x_reg, x_next;
    logic        err_reg, err_next;
    logic [15:0] ea_reg;

    logic [2:0]  mode;
    logic [2:0]  rn;
    logic [15:0] step_nat;
    logic [15:0] step_mod;
    logic        deferred;

    assign mode = spec_reg[5:3];
    assign rn   = spec_reg[2:0];

    // SP and PC always step by 2 so they stay word aligned.
    assign step_nat = (!byte_reg || rn == SP_REG || rn == PC_REG) ? 16'd2 : 16'd1;
    // Deferred auto modes step over a pointer word, so they always use 2.
    assign step_mod = (mode == 3'd3 || mode == 3'd5) ? 16'd2 : step_nat;
    assign deferred = (mode == 3'd3 || mode == 3'd5 || mode == 3'd7);

    // Next-state, datapath and register/memory port control.
    always_comb begin
        state_next = state_reg;
        tmp_next   = tmp_reg;
        x_next     = x_reg;
        err_next   = err_reg;
        rf_sel     = rn;
        rf_we      = 1'b0;
        rf_wdata   = 16'd0;
        mem_req    = 1'b0;
        mem_addr   = 16'd0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    err_next   = 1'b0;
                    state_next = (spec[5:4] == 2'b11) ? S_PCRD : S_REG;
                end
            end
            S_REG: begin
                case (mode)
                    3'd0: tmp_next = {13'd0, rn};
                    3'd1: tmp_next = rf_rdata;
                    3'd2, 3'd3: begin
                        tmp_next = rf_rdata;
                        rf_we    = 1'b1;
                        rf_wdata = rf_rdata + step_mod;
                    end
                    3'd4, 3'd5: begin
                        tmp_next = rf_rdata - step_mod;
                        rf_we    = 1'b1;
                        rf_wdata = rf_rdata - step_mod;
                    end
                    default: tmp_next = rf_rdata + x_reg;
                endcase
                if (deferred) begin
                    // A pointer fetch from an odd address never reaches memory.
                    if (TRAP_EN && tmp_next[0]) begin
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_MEM;
                    end
                end else begin
                    if (TRAP_EN && !byte_reg && mode != 3'd0 && tmp_next[0])
                        err_next = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_PCRD: begin
                rf_sel = PC_REG;
                if (TRAP_EN && rf_rdata[0]) begin
                    tmp_next   = rf_rdata;
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = rf_rdata;
                    if (mem_ack) begin
                        x_next     = mem_rdata;
                        state_next = S_PCINC;
                    end
                end
            end
            S_PCINC: begin
                rf_sel     = PC_REG;
                rf_we      = 1'b1;
                rf_wdata   = rf_rdata + 16'd2;
                state_next = S_REG;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = tmp_reg;
                if (mem_ack) begin
                    tmp_next   = mem_rdata;
                    err_next   = TRAP_EN && !byte_reg && mem_rdata[0];
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            spec_reg  <= 6'd0;
            byte_reg  <= 1'b0;
            tmp_reg   <= 16'd0;
            x_reg     <= 16'd0;
            err_reg   <= 1'b0;
            ea_reg    <= 16'd0;
        end else begin
            state_reg <= state_next;
            tmp_reg   <= tmp_next;
            x_reg     <= x_next;
            err_reg   <= err_next;
            if (state_reg == S_IDLE && start) begin
                spec_reg <= spec;
                byte_reg <= byte_op;
            end
            if (state_reg == S_DONE)
                ea_reg <= tmp_reg;
        end
    end

    // ea shows the new address during done and keeps it until the next done.
    assign busy   = (state_reg != S_IDLE);
    assign done   = (state_reg == S_DONE);
    assign ea     = done ? tmp_reg : ea_reg;
    assign is_reg = done && (mode == 3'd0);
    assign err    = TRAP_EN && done && err_reg;

endmodule

// File: tb/tb_operand_addr_seq.sv
// Testbench for operand_addr_seq.
// Models the register file and a memory with programmable ack wait states.
// Expected results go into a scoreboard and are checked when done pulses.
module tb_operand_addr_seq;

`ifdef ODD_ADDR_TRAP_EN
    localparam logic TB_TRAP = 1'b1;
`else
    localparam logic TB_TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  spec = 6'd0;
    logic        byte_op = 1'b0;
    logic        busy, done, is_reg, rf_we, mem_req, err;
    logic [15:0] ea, rf_wdata, mem_addr, rf_rdata;
    logic [2:0]  rf_sel;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_ack;

    logic [15:0] regs [8];
    logic [15:0] mem [65536];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_sel = 3'd0;
    logic [15:0] pre_data = 16'd0;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int req_cnt = 0;
    int stab_err = 0;
    int done_cnt = 0;
    int waits = 0;
    int wcnt = 0;
    logic resp_ack = 1'b0;
    logic spur = 1'b0;
    logic in_xfer = 1'b0;
    logic [15:0] first_addr = 16'd0;

    logic [17:0] exp_q [$];
    string       tag_q [$];

    operand_addr_seq dut (
        .clk(clk), .reset(reset), .start(start), .spec(spec), .byte_op(byte_op),
        .busy(busy), .done(done), .ea(ea), .is_reg(is_reg),
        .rf_sel(rf_sel), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    assign rf_rdata = regs[rf_sel];
    assign mem_ack  = resp_ack | spur;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Register file: DUT writes take priority over bench preloads.
    always @(posedge clk) begin
        if (rf_we) begin
            regs[rf_sel] <= rf_wdata;
            wr_cnt <= wr_cnt + 1;
        end else if (pre_we) begin
            regs[pre_sel] <= pre_data;
        end
    end

    // Memory responder: acks after 'waits' request cycles, watches address stability.
    always @(negedge clk) begin
        if (reset || resp_ack) begin
            wcnt    = 0;
            in_xfer = 1'b0;
        end
        resp_ack = 1'b0;
        if (mem_req && !reset) begin
            req_cnt++;
            if (!in_xfer) begin
                in_xfer    = 1'b1;
                first_addr = mem_addr;
            end else if (mem_addr != first_addr) begin
                stab_err++;
            end
            if (wcnt >= waits) begin
                resp_ack  = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                wcnt++;
            end
        end
    end

    // Scoreboard consumer: every done pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(ea), 32'hFFFFFFFF);
            end else begin
                logic [17:0] e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                $display("txn %s: ea=%h is_reg=%b err=%b", t, ea, is_reg, err);
                chk({t, ".ea"}, 32'(ea), 32'(e[15:0]));
                chk({t, ".is_reg"}, 32'(is_reg), 32'(e[16]));
                chk({t, ".err"}, 32'(err), 32'(e[17]));
            end
        end
    end

    task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_sel = r; pre_data = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [5:0] s, input logic b,
                          input int w, input int hold, input logic [15:0] eea,
                          input logic eis, input logic eerr, input int elat,
                          input int ewr, input int ereq);
        int wr0, rq0, dn0, n;
        waits = w;
        @(posedge clk); #1;
        wr0 = wr_cnt; rq0 = req_cnt; dn0 = done_cnt;
        exp_q.push_back({eerr, eis, eea});
        tag_q.push_back(tag);
        spec = s; byte_op = b; start = 1'b1; n = 0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(elat));
        @(negedge clk); #1;
        chk({tag, ".done_count"}, 32'(done_cnt - dn0), 32'd1);
        chk({tag, ".rf_writes"}, 32'(wr_cnt - wr0), 32'(ewr));
        chk({tag, ".req_cycles"}, 32'(req_cnt - rq0), 32'(ereq));
        if (exp_q.size() != 0) begin
            chk({tag, ".sb_left"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, dn0, st0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.mem_req", 32'(mem_req), 0);
        chk("rst.rf_we", 32'(rf_we), 0);
        chk("rst.ea", 32'(ea), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.is_reg", 32'(is_reg), 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) set_reg(3'(i), 16'd0);

        // mode 0: register operand
        run_op("m0", 6'o03, 1'b0, 0, 1, 16'h0003, 1'b1, 1'b0, 2, 0, 0);

        // mode 1, start held an extra cycle while busy (ignored)
        set_reg(3, 16'h1000);
        run_op("m1", 6'o13, 1'b0, 0, 2, 16'h1000, 1'b0, 1'b0, 2, 0, 0);

        // mode 2 byte, step 1
        set_reg(2, 16'h2001);
        run_op("m2b", 6'o22, 1'b1, 0, 1, 16'h2001, 1'b0, 1'b0, 2, 1, 0);
        chk("m2b.R2", 32'(regs[2]), 32'h2002);

        // mode 4 byte on SP steps 2
        set_reg(6, 16'h0400);
        run_op("m4sp", 6'o46, 1'b1, 0, 1, 16'h03FE, 1'b0, 1'b0, 2, 1, 0);
        chk("m4sp.R6", 32'(regs[6]), 32'h03FE);

        // mode 4 byte on R5 steps 1
        set_reg(5, 16'h0010);
        run_op("m4b", 6'o45, 1'b1, 0, 1, 16'h000F, 1'b0, 1'b0, 2, 1, 0);
        chk("m4b.R5", 32'(regs[5]), 32'h000F);

        // mode 2 word with stray mem_ack throughout
        set_reg(0, 16'h0010);
        spur = 1'b1;
        run_op("m2spur", 6'o20, 1'b0, 0, 1, 16'h0010, 1'b0, 1'b0, 2, 1, 0);
        spur = 1'b0;
        chk("m2spur.R0", 32'(regs[0]), 32'h0012);

        // mode 6 PC-relative: X fetched at PC, EA = (PC+2)+X
        set_reg(7, 16'h0100);
        mem[16'h0100] = 16'h0010;
        run_op("m6pc", 6'o67, 1'b0, 0, 1, 16'h0112, 1'b0, 1'b0, 4, 1, 1);
        chk("m6pc.PC", 32'(regs[7]), 32'h0102);

        // mode 3 with 3 wait states
        set_reg(1, 16'h0200);
        mem[16'h0200] = 16'h3000;
        st0 = stab_err;
        run_op("m3w", 6'o31, 1'b0, 3, 1, 16'h3000, 1'b0, 1'b0, 6, 1, 4);
        chk("m3w.R1", 32'(regs[1]), 32'h0202);
        chk("m3w.addr", 32'(first_addr), 32'h0200);
        chk("m3w.addr_stable", 32'(stab_err - st0), 0);

        // mode 7 PC-relative deferred, 1 wait state per access
        mem[16'h0102] = 16'h0020;
        mem[16'h0124] = 16'h4000;
        run_op("m7pc", 6'o77, 1'b0, 1, 1, 16'h4000, 1'b0, 1'b0, 7, 1, 4);
        chk("m7pc.PC", 32'(regs[7]), 32'h0104);

        // mode 5 byte: deferred decrement steps 2 regardless of byte_op
        set_reg(4, 16'h0300);
        mem[16'h02FE] = 16'h5555;
        run_op("m5b", 6'o54, 1'b1, 0, 1, 16'h5555, 1'b0, 1'b0, 3, 1, 1);
        chk("m5b.R4", 32'(regs[4]), 32'h02FE);

        // odd final word EA
        set_reg(3, 16'h1001);
        run_op("m1odd", 6'o13, 1'b0, 0, 1, 16'h1001, 1'b0, TB_TRAP, 2, 0, 0);

        // odd deferred pointer
        set_reg(4, 16'h0101);
        mem[16'h0101] = 16'h7000;
        if (TB_TRAP)
            run_op("m3odd", 6'o34, 1'b0, 0, 1, 16'h0101, 1'b0, 1'b1, 2, 1, 0);
        else
            run_op("m3odd", 6'o34, 1'b0, 0, 1, 16'h7000, 1'b0, 1'b0, 3, 1, 1);
        chk("m3odd.R4", 32'(regs[4]), 32'h0103);

        // reset while waiting in MEM
        set_reg(1, 16'h0600);
        mem[16'h0600] = 16'h1234;
        waits = 20;
        @(posedge clk); #1;
        dn0 = done_cnt;
        spec = 6'o31; byte_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstmem.req_seen", 32'(mem_req), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rstmem.mem_req", 32'(mem_req), 0);
        chk("rstmem.busy", 32'(busy), 0);
        chk("rstmem.rf_we", 32'(rf_we), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rstmem.no_done", 32'(done_cnt - dn0), 0);
        chk("rstmem.R1", 32'(regs[1]), 32'h0602);
        chk("rstmem.idle", 32'(busy), 0);
        waits = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
